// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  // Largest operand width the controller is built for.
  localparam int unsigned MaxWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the per-bit datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: walks one full_adder across WIDTH-bit operands,
// LSB first, one bit per clock, and reports completion with a one-cycle pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  if (WIDTH < 1 || WIDTH > MaxWidth) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;

  logic load, step, finish, last;
  logic fa_sum, fa_carry;

  full_adder u_full_adder (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // Sum shift register contents after this edge: new bit enters at the MSB.
  always_comb begin
    s_next            = s_sh_q >> 1;
    s_next[WIDTH-1]   = fa_sum;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // Accepting here gives back-to-back operations with no idle gap.
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/sum shift registers, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (load) begin
        a_sh_q  <= a;
        b_sh_q  <= b;
        carry_q <= cin;
        cnt_q   <= '0;
      end
      if (step) begin
        a_sh_q  <= a_sh_q >> 1;
        b_sh_q  <= b_sh_q >> 1;
        s_sh_q  <= s_next;
        carry_q <= fa_carry;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (finish) begin
        sum_q  <= s_next;
        cout_q <= fa_carry;
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Present operands with start for exactly one accept edge.
  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    @(posedge clk);
    #1;
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count busy cycles until done is seen, bounded.
  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
  endtask

  task automatic test_basic();
    int bc;
    bit seen;
    start_op(8'h5A, 8'h3C, 1'b0);
    wait_done(bc, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", seen); end
    n_tests++; if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    n_tests++; if (sum !== 8'h96) begin n_fail++; $display("FAIL basic_sum: got %h expected 96", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", cout); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_tests++; if (sum !== 8'h96) begin n_fail++; $display("FAIL basic_sum_hold: got %h expected 96", sum); end
  endtask

  task automatic test_overflow();
    int bc;
    bit seen;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(bc, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ovf1_done: got %b expected 1", seen); end
    n_tests++; if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL ovf1_result: got %h expected 100", {cout, sum}); end
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(bc, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ovf2_done: got %b expected 1", seen); end
    n_tests++; if ({cout, sum} !== 9'h1FF) begin n_fail++; $display("FAIL ovf2_result: got %h expected 1ff", {cout, sum}); end
  endtask

  task automatic test_ignore_start();
    int bc;
    bit seen;
    int extra;
    start_op(8'h01, 8'h02, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(bc, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b expected 1", seen); end
    n_tests++; if ({cout, sum} !== 9'h003) begin n_fail++; $display("FAIL ign_result: got %h expected 003", {cout, sum}); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL ign_no_second_op: got %0d active cycles expected 0", extra); end
    n_tests++; if (sum !== 8'h03) begin n_fail++; $display("FAIL ign_sum_hold: got %h expected 03", sum); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h80; b = 8'h80;
    gaps = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (!(busy || done)) gaps++;
      if (k == 8) begin
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", done); end
        n_tests++; if ({cout, sum} !== 9'h033) begin n_fail++; $display("FAIL b2b_result1: got %h expected 033", {cout, sum}); end
      end
      if (k == 9) start = 1'b0;
      if (k == 17) begin
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b expected 1", done); end
        n_tests++; if ({cout, sum} !== 9'h100) begin n_fail++; $display("FAIL b2b_result2: got %h expected 100", {cout, sum}); end
      end
    end
    n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_no_gap: got %0d idle cycles expected 0", gaps); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int bc;
    bit seen;
    int dones;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", done); end
    n_tests++; if ({cout, sum} !== 9'h000) begin n_fail++; $display("FAIL mid_rst_result: got %h expected 000", {cout, sum}); end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL mid_rst_no_done: got %0d expected 0", dones); end
    start_op(8'h12, 8'h34, 1'b1);
    wait_done(bc, seen);
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_rst_new_done: got %b expected 1", seen); end
    n_tests++; if ({cout, sum} !== 9'h047) begin n_fail++; $display("FAIL mid_rst_new_result: got %h expected 047", {cout, sum}); end
  endtask

  task automatic test_width1();
    // Full-adder truth table indexed by {a,b,cin}, entries are {cout,sum}.
    logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(posedge clk);
      #1;
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      @(negedge clk);
      n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL w1_busy[%0d]: got %b expected 1", i, busy1); end
      @(negedge clk);
      n_tests++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL w1_done[%0d]: got %b expected 1", i, done1); end
      n_tests++; if ({cout1, sum1} !== exp_tab[i]) begin n_fail++; $display("FAIL w1_result[%0d]: got %b expected %b", i, {cout1, sum1}, exp_tab[i]); end
    end
  endtask

  initial begin
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
